// File: rtl/bits_change_recorder.sv
// bits_change_recorder
// Watches a small bit bus and queues a {timestamp, bits} row whenever the
// bus changes while recording is enabled. A START row is always queued so
// the initial state of the bus is captured. Rows are read out through a
// valid/ready port. A row becomes visible one edge after it is queued.
//
// Optional feature: define BITS_CHANGE_RECORDER_DROP_CNT_EN to add the
// DROPPED_o saturating count of records lost to a full FIFO.
module bits_change_recorder #(
  parameter int WIDTH    = 4,
  parameter int TS_WIDTH = 32,
  parameter int DEPTH    = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      ENABLE_i,
  input  logic [WIDTH-1:0]          BITS_i,
  input  logic                      rd_ready_i,
  output logic                      rd_valid_o,
  output logic [TS_WIDTH-1:0]       rd_ts_o,
  output logic [WIDTH-1:0]          rd_bits_o,
  output logic                      ACTIVE_o,
  output logic                      OVERFLOW_o,
  output logic [$clog2(DEPTH):0]    COUNT_o
`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
  ,
  output logic [15:0]               DROPPED_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                enable_q;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [WIDTH-1:0]    last_q, last_d;
  logic                ovf_q, ovf_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                fresh_q, fresh_d;

  logic [TS_WIDTH-1:0] mem_ts   [DEPTH];
  logic [WIDTH-1:0]    mem_bits [DEPTH];

  logic                push_req;
  logic [TS_WIDTH-1:0] push_ts;
  logic                push_ok;
  logic                drop;
  logic                pop;
  logic                full;

`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
  logic [15:0]         dropped_q, dropped_d;
`endif

  // Next-state logic for the recording FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ENABLE_i && !enable_q) state_d = S_START;
      S_START: state_d = ENABLE_i ? S_RUN : S_IDLE;
      S_RUN:   if (!ENABLE_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Timestamp, change detection and the push request for this cycle.
  always_comb begin
    ts_d     = ts_q;
    last_d   = last_q;
    push_req = 1'b0;
    push_ts  = '0;
    unique case (state_q)
      S_START: begin
        ts_d     = '0;
        last_d   = BITS_i;
        push_req = 1'b1;
        push_ts  = '0;
      end
      S_RUN: begin
        ts_d     = ts_q + TS_WIDTH'(1);
        last_d   = BITS_i;
        push_req = (BITS_i != last_q);
        push_ts  = ts_d;
      end
      default: ;
    endcase
  end

  // FIFO occupancy, overflow flag and head-visibility bookkeeping.
  always_comb begin
    pop     = rd_valid_o && rd_ready_i;
    full    = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot a full FIFO needs.
    push_ok = push_req && (!full || pop);
    drop    = push_req && !push_ok;

    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    // The pushed record is the new head only if nothing older remains.
    fresh_d = push_ok && (count_q == CW'(pop));

    ovf_d = ovf_q;
    if (state_q == S_START) ovf_d = 1'b0;
    if (drop)               ovf_d = 1'b1;

`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
    dropped_d = dropped_q;
    if (state_q == S_START) dropped_d = '0;
    if (drop && dropped_d != 16'hFFFF) dropped_d = dropped_d + 16'd1;
`endif
  end

  // Control and status registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      enable_q <= 1'b0;
      ts_q     <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fresh_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      enable_q <= ENABLE_i;
      ts_q     <= ts_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      fresh_q  <= fresh_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
  // Saturating count of dropped records.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) dropped_q <= '0;
    else         dropped_q <= dropped_d;
  end

  assign DROPPED_o = dropped_q;
`endif

  // Record storage.
  // NOTE: the storage array has no reset; a zero count and reset pointers make stale rows unreachable.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_ts[wr_ptr_q]   <= push_ts;
      mem_bits[wr_ptr_q] <= BITS_i;
    end
  end

  assign rd_valid_o = (count_q != '0) && !fresh_q;
  assign rd_ts_o    = rd_valid_o ? mem_ts[rd_ptr_q]   : '0;
  assign rd_bits_o  = rd_valid_o ? mem_bits[rd_ptr_q] : '0;
  assign ACTIVE_o   = (state_q != S_IDLE);
  assign OVERFLOW_o = ovf_q;
  assign COUNT_o    = count_q;

endmodule

// File: tb/tb_bits_change_recorder.sv
// Testbench for bits_change_recorder: randomized and directed stimulus
// against a queue-based model of the recorder. A second instance with an
// 8-bit timestamp covers timestamp wrap.
module tb_bits_change_recorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, ready;
  logic [3:0]  bits;
  logic        valid, active, ovf;
  logic [31:0] ts;
  logic [3:0]  rbits;
  logic [4:0]  count;

  logic        en8, ready8;
  logic [3:0]  bits8;
  logic        valid8, active8, ovf8;
  logic [7:0]  ts8;
  logic [3:0]  rbits8;
  logic [4:0]  count8;

`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
  logic [15:0] dropped, dropped8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bits_change_recorder #(.WIDTH(4), .TS_WIDTH(32), .DEPTH(16)) dut (
    .clk_i(clk), .reset_i(rst), .ENABLE_i(en), .BITS_i(bits),
    .rd_ready_i(ready), .rd_valid_o(valid), .rd_ts_o(ts), .rd_bits_o(rbits),
    .ACTIVE_o(active), .OVERFLOW_o(ovf), .COUNT_o(count)
`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
    , .DROPPED_o(dropped)
`endif
  );

  bits_change_recorder #(.WIDTH(4), .TS_WIDTH(8), .DEPTH(16)) dut8 (
    .clk_i(clk), .reset_i(rst), .ENABLE_i(en8), .BITS_i(bits8),
    .rd_ready_i(ready8), .rd_valid_o(valid8), .rd_ts_o(ts8), .rd_bits_o(rbits8),
    .ACTIVE_o(active8), .OVERFLOW_o(ovf8), .COUNT_o(count8)
`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
    , .DROPPED_o(dropped8)
`endif
  );

  // ---------------- reference model (main instance) ----------------
  typedef struct packed {
    logic [31:0] e;     // edge at which the record entered the FIFO
    logic [31:0] ts;
    logic [3:0]  bits;
  } rec_t;

  rec_t        mq[$];
  int unsigned cyc = 0;         // edges seen so far
  int          m_since;         // -1 when idle, else cycles since START
  logic        m_en_prev;
  logic [3:0]  m_last;
  logic        m_ovf;
  int          m_drop;

  task automatic model_reset();
    mq.delete();
    m_since   = -1;
    m_en_prev = 1'b0;
    m_last    = 4'h0;
    m_ovf     = 1'b0;
    m_drop    = 0;
  endtask

  function automatic logic exp_valid();
    return (mq.size() > 0) && (mq[0].e < cyc);
  endfunction

  // Advance one clock: update the model from the inputs the DUT is about to
  // sample, then wait for the edge and settle.
  task automatic step();
    logic pop, push;
    rec_t r;
    if (rst) begin
      model_reset();
    end else begin
      pop  = exp_valid() && ready;
      push = 1'b0;
      r    = '0;
      if (m_since == 0) begin
        m_ovf  = 1'b0;
        m_drop = 0;
        push   = 1'b1;
        r.ts   = 32'd0;
      end else if (m_since > 0) begin
        push = (bits != m_last);
        r.ts = 32'(m_since);
      end
      if (m_since >= 0) m_last = bits;
      r.bits = bits;
      r.e    = cyc + 1;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < 16) mq.push_back(r);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (m_since < 0) m_since = (en && !m_en_prev) ? 0 : -1;
      else             m_since = en ? m_since + 1 : -1;
      m_en_prev = en;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain_main();
    ready = 1'b1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) step();
    ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 0; ready = 0; bits = 0; en8 = 0; ready8 = 0; bits8 = 0;
    step(); step();
    checks++; if (count !== 5'd0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (ovf !== 1'b0)    begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf); end
    checks++; if (ts !== 32'd0 || rbits !== 4'd0) begin failures++; $display("FAIL reset_head got=%0d/%h exp=0/0", ts, rbits); end
    checks++; if (count8 !== 5'd0 || valid8 !== 1'b0) begin failures++; $display("FAIL reset_dut8 count=%0d valid=%b exp=0/0", count8, valid8); end
`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
    checks++; if (dropped !== 16'd0) begin failures++; $display("FAIL reset_dropped got=%0d exp=0", dropped); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_start_single_change();
    logic [31:0] exp_ts[2]   = '{32'd0, 32'd5};
    logic [3:0]  exp_bits[2] = '{4'h3, 4'h5};
    ready = 0; bits = 4'h3; en = 1;
    step();                          // rising edge seen -> START
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL start_active got=%b exp=1", active); end
    step();                          // START pushes {0,3}
    checks++; if (valid !== 1'b0 || count !== 5'd1) begin failures++; $display("FAIL start_latency valid=%b count=%0d exp=0/1", valid, count); end
    for (int k = 1; k <= 4; k++) step();
    bits = 4'h5;
    step();                          // RUN cycle 5
    step();
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL single_change_count got=%0d exp=2", count); end
    en = 0; step();
    ready = 1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (valid !== 1'b1 || ts !== exp_ts[i] || rbits !== exp_bits[i]) begin
        failures++;
        $display("FAIL single_change_rec%0d got=%b/%0d/%h exp=1/%0d/%h", i, valid, ts, rbits, exp_ts[i], exp_bits[i]);
      end
      step();
    end
    ready = 0;
    checks++; if (count !== 5'd0 || valid !== 1'b0) begin failures++; $display("FAIL single_change_empty count=%0d valid=%b exp=0/0", count, valid); end
  endtask

  task automatic test_no_change();
    ready = 0; bits = 4'hA; en = 1;
    step(); step();
    for (int k = 0; k < 50; k++) step();
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL no_change_count got=%0d exp=1", count); end
    checks++; if (ts !== 32'd0 || rbits !== 4'hA) begin failures++; $display("FAIL no_change_head got=%0d/%h exp=0/a", ts, rbits); end
    en = 0; step();
    drain_main();
  endtask

  task automatic test_backpressure();
    ready = 0; bits = 4'h0; en = 1;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      bits = 4'((i % 15) + 1);
      step();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL bp_count got=%0d exp=16", count); end
    checks++; if (ovf !== 1'b1)    begin failures++; $display("FAIL bp_overflow got=%b exp=1", ovf); end
`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
    checks++; if (dropped !== 16'd5) begin failures++; $display("FAIL bp_dropped got=%0d exp=5", dropped); end
`endif
    en = 0; step();
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_overflow_sticky got=%b exp=1", ovf); end
    ready = 1;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (valid !== 1'b1 || ts !== 32'(k) || rbits !== 4'(k)) begin
        failures++;
        $display("FAIL bp_drain_rec%0d got=%b/%0d/%h exp=1/%0d/%h", k, valid, ts, rbits, k, k);
      end
      step();
    end
    ready = 0;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL bp_drained_count got=%0d exp=0", count); end
    bits = 4'h0; en = 1;
    step(); step();
    checks++; if (ovf !== 1'b0 || count !== 5'd1) begin failures++; $display("FAIL bp_restart ovf=%b count=%0d exp=0/1", ovf, count); end
`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
    checks++; if (dropped !== 16'd0) begin failures++; $display("FAIL bp_restart_dropped got=%0d exp=0", dropped); end
`endif
    en = 0; step();
    drain_main();
  endtask

  task automatic test_full_pop();
    ready = 0; bits = 4'h0; en = 1;
    step(); step();
    for (int i = 0; i < 15; i++) begin
      bits = 4'((i % 15) + 1);
      step();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_fill_count got=%0d exp=16", count); end
    ready = 1;
    for (int i = 0; i < 10; i++) begin
      bits = 4'((i % 15) + 1);
      step();
      checks++;
      if (count !== 5'd16 || ovf !== 1'b0) begin
        failures++;
        $display("FAIL full_pop_cycle%0d count=%0d ovf=%b exp=16/0", i, count, ovf);
      end
    end
    ready = 0; en = 0; step();
    drain_main();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_ts[3]   = '{8'd0, 8'd255, 8'd1};
    logic [3:0] exp_bits[3] = '{4'h0, 4'h1, 4'h0};
    ready8 = 0; bits8 = 4'h0; en8 = 1;
    step(); step();
    for (int k = 1; k <= 260; k++) begin
      bits8 = (k >= 255 && k < 257) ? 4'h1 : 4'h0;
      step();
    end
    en8 = 0; step();
    checks++; if (count8 !== 5'd3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", count8); end
    ready8 = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid8 !== 1'b1 || ts8 !== exp_ts[i] || rbits8 !== exp_bits[i]) begin
        failures++;
        $display("FAIL wrap_rec%0d got=%b/%0d/%h exp=1/%0d/%h", i, valid8, ts8, rbits8, exp_ts[i], exp_bits[i]);
      end
      step();
    end
    ready8 = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(19) == 0) en = ~en;
      if ($urandom_range(2) == 0)  bits = 4'($urandom);
      ready = ($urandom_range(2) != 0);
      step();
      checks++;
      if (count !== 5'(mq.size()) || valid !== exp_valid() || active !== (m_since >= 0) || ovf !== m_ovf) begin
        failures++;
        $display("FAIL rand_status c=%0d count=%0d/%0d valid=%b/%b active=%b/%b ovf=%b/%b",
                 c, count, mq.size(), valid, exp_valid(), active, (m_since >= 0), ovf, m_ovf);
      end
      if (exp_valid()) begin
        checks++;
        if (ts !== mq[0].ts || rbits !== mq[0].bits) begin
          failures++;
          $display("FAIL rand_head c=%0d got=%0d/%h exp=%0d/%h", c, ts, rbits, mq[0].ts, mq[0].bits);
        end
      end
`ifdef BITS_CHANGE_RECORDER_DROP_CNT_EN
      checks++;
      if (dropped !== 16'(m_drop)) begin failures++; $display("FAIL rand_dropped c=%0d got=%0d exp=%0d", c, dropped, m_drop); end
`endif
    end
    en = 0; ready = 0; step();
    drain_main();
  endtask

  task automatic test_reset_mid();
    ready = 0; bits = 4'h1; en = 1;
    step(); step();
    bits = 4'h2; step();
    bits = 4'h3; step();
    checks++; if (count !== 5'd3 || active !== 1'b1) begin failures++; $display("FAIL mid_pre count=%0d active=%b exp=3/1", count, active); end
    #3;
    rst = 1'b1; en = 0;
    #1;
    model_reset();
    checks++;
    if (valid !== 1'b0 || count !== 5'd0 || active !== 1'b0) begin
      failures++;
      $display("FAIL mid_async valid=%b count=%0d active=%b exp=0/0/0", valid, count, active);
    end
    step();
    rst = 1'b0;
    step();
    checks++; if (count !== 5'd0 || ovf !== 1'b0) begin failures++; $display("FAIL mid_after count=%0d ovf=%b exp=0/0", count, ovf); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_single_change();
    test_no_change();
    test_backpressure();
    test_full_pop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
